countdown_timer: RTL and testbench

//  Down-counting hh:mm:ss timer; companion to the up-counting time-of-day clock.

---
 rtl/countdown_timer.sv | 217 +++++++++++++++++++++
 tb/tb_countdown_timer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: hh:mm:ss down-counter. A prescaler divides clk down to a
// one-second tick, and the timer pulses done_o when the count reaches 00:00:00.
// Optional feature: define AUTO_RELOAD_EN to reload the preset when the count
// reaches zero, so the timer keeps running instead of stopping in DONE.
module countdown_timer #(
    parameter logic [3:0] FREQ       = 4'd10,
    parameter logic [2:0] UNIT       = 3'd6,
    parameter logic [3:0] TOTAL_TIME = 4'd12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic [2:0] sec_i,
    input  logic [2:0] min_i,
    input  logic [3:0] hour_i,
    output logic [2:0] sec_o,
    output logic [2:0] min_o,
    output logic [3:0] hour_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sec_q, sec_d;
    logic [2:0] min_q, min_d;
    logic [3:0] hour_q, hour_d;
    logic [4:0] presc_q, presc_d;
    logic       done_q, done_d;

`ifdef AUTO_RELOAD_EN
    logic [2:0] psec_q, psec_d;
    logic [2:0] pmin_q, pmin_d;
    logic [3:0] phour_q, phour_d;
    logic       preset_zero;
`endif

    logic [2:0] sec_clamp, min_clamp;
    logic [3:0] hour_clamp;
    logic [2:0] sec_dec, min_dec;
    logic [3:0] hour_dec;
    logic       value_zero;
    logic       hits_zero;
    logic       advance;
    logic       tick;

    // Clamp the preset inputs, form the borrow-chain decrement and the tick
    always_comb begin
        sec_clamp  = (sec_i >= UNIT) ? UNIT - 3'd1 : sec_i;
        min_clamp  = (min_i >= UNIT) ? UNIT - 3'd1 : min_i;
        hour_clamp = (hour_i >= TOTAL_TIME) ? TOTAL_TIME - 4'd1 : hour_i;

        value_zero = (sec_q == 3'd0) && (min_q == 3'd0) && (hour_q == 4'd0);
`ifdef AUTO_RELOAD_EN
        preset_zero = (psec_q == 3'd0) && (pmin_q == 3'd0) && (phour_q == 4'd0);
`endif

        // Hour underflow cannot occur: RUN is never entered with a zero value.
        sec_dec  = sec_q;
        min_dec  = min_q;
        hour_dec = hour_q;
        if (sec_q != 3'd0) begin
            sec_dec = sec_q - 3'd1;
        end else if (min_q != 3'd0) begin
            min_dec = min_q - 3'd1;
            sec_dec = UNIT - 3'd1;
        end else begin
            hour_dec = hour_q - 4'd1;
            min_dec  = UNIT - 3'd1;
            sec_dec  = UNIT - 3'd1;
        end
        hits_zero = (sec_dec == 3'd0) && (min_dec == 3'd0) && (hour_dec == 4'd0);

        // The pause edge does not advance the prescaler but the resume edge
        // does, so a pause/resume pair loses no time relative to the RUN cycles.
        advance = ((state_q == S_RUN) && !pause_i) ||
                  ((state_q == S_PAUSE) && start_i && !pause_i && !load_i);
        tick    = advance && (presc_q == {1'b0, FREQ - 4'd1});
    end

    // Next state and datapath update; priority is load > pause > start
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        presc_d = presc_q;
        done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
        psec_d  = psec_q;
        pmin_d  = pmin_q;
        phour_d = phour_q;
`endif

        if (load_i && (state_q != S_RUN)) begin
            sec_d   = sec_clamp;
            min_d   = min_clamp;
            hour_d  = hour_clamp;
            presc_d = 5'd0;
            state_d = S_IDLE;
`ifdef AUTO_RELOAD_EN
            psec_d  = sec_clamp;
            pmin_d  = min_clamp;
            phour_d = hour_clamp;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    if (pause_i) begin
                        state_d = S_PAUSE;
                    end
                end
                S_IDLE: begin
                    if (start_i && !pause_i) begin
                        if (value_zero) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            presc_d = 5'd0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_i && !pause_i) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
`ifdef AUTO_RELOAD_EN
                    if (start_i && !pause_i && !preset_zero) begin
                        sec_d   = psec_q;
                        min_d   = pmin_q;
                        hour_d  = phour_q;
                        presc_d = 5'd0;
                        state_d = S_RUN;
                    end
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (advance) begin
            if (tick) begin
                presc_d = 5'd0;
                if (hits_zero) begin
                    done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                    sec_d   = psec_q;
                    min_d   = pmin_q;
                    hour_d  = phour_q;
                    state_d = S_RUN;
`else
                    sec_d   = 3'd0;
                    min_d   = 3'd0;
                    hour_d  = 4'd0;
                    state_d = S_DONE;
`endif
                end else begin
                    sec_d  = sec_dec;
                    min_d  = min_dec;
                    hour_d = hour_dec;
                end
            end else begin
                presc_d = presc_q + 5'd1;
            end
        end
    end

    // State and datapath registers; synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sec_q   <= 3'd0;
            min_q   <= 3'd0;
            hour_q  <= 4'd0;
            presc_q <= 5'd0;
            done_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
            psec_q  <= 3'd0;
            pmin_q  <= 3'd0;
            phour_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            presc_q <= presc_d;
            done_q  <= done_d;
`ifdef AUTO_RELOAD_EN
            psec_q  <= psec_d;
            pmin_q  <= pmin_d;
            phour_q <= phour_d;
`endif
        end
    end

    // Outputs come straight from registers
    always_comb begin
        sec_o  = sec_q;
        min_o  = min_q;
        hour_o = hour_q;
        busy_o = (state_q == S_RUN);
        done_o = done_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: a seconds-remaining reference model checked
// every cycle, plus directed scenarios with hand-computed literal values.
module tb_countdown_timer;

    localparam int FREQ = 10;
    localparam int UNIT = 6;
    localparam int TT   = 12;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_i, start_i, pause_i;
    logic [2:0] sec_i, min_i;
    logic [3:0] hour_i;
    logic [2:0] sec_o, min_o;
    logic [3:0] hour_o;
    logic       busy_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer #(
        .FREQ      (4'd10),
        .UNIT      (3'd6),
        .TOTAL_TIME(4'd12)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_i),
        .start_i(start_i),
        .pause_i(pause_i),
        .sec_i  (sec_i),
        .min_i  (min_i),
        .hour_i (hour_i),
        .sec_o  (sec_o),
        .min_o  (min_o),
        .hour_o (hour_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining time kept as a plain count of seconds
    int m_st = M_IDLE;
    int m_rem = 0;
    int m_pre = 0;
    int m_phase = 0;
    bit m_done = 1'b0;
    bit m_adv;

    function automatic int clampv(input int v, input int lim);
        return (v >= lim) ? lim - 1 : v;
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_st = M_IDLE; m_rem = 0; m_pre = 0; m_phase = 0;
        end else begin
            m_adv = ((m_st == M_RUN) && !pause_i) ||
                    ((m_st == M_PAUSE) && start_i && !pause_i && !load_i);
            if (load_i && m_st != M_RUN) begin
                m_rem = clampv(int'(hour_i), TT) * UNIT * UNIT
                      + clampv(int'(min_i), UNIT) * UNIT
                      + clampv(int'(sec_i), UNIT);
                m_pre = m_rem;
                m_phase = 0;
                m_st = M_IDLE;
            end else if (pause_i) begin
                if (m_st == M_RUN) m_st = M_PAUSE;
            end else if (start_i) begin
                if (m_st == M_IDLE) begin
                    if (m_rem == 0) begin
                        m_st = M_DONE; m_done = 1'b1;
                    end else begin
                        m_st = M_RUN; m_phase = 0;
                    end
                end else if (m_st == M_PAUSE) begin
                    m_st = M_RUN;
                end
`ifdef AUTO_RELOAD_EN
                else if (m_st == M_DONE && m_pre != 0) begin
                    m_rem = m_pre; m_phase = 0; m_st = M_RUN;
                end
`endif
            end
            if (m_adv) begin
                m_phase++;
                if (m_phase == FREQ) begin
                    m_phase = 0;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
                        m_rem = m_pre;
`else
                        m_st = M_DONE;
`endif
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model, just after the edge
    always begin
        @(posedge clk);
        #1;
        check("cmp_sec",  sec_o,  m_rem % UNIT);
        check("cmp_min",  min_o,  (m_rem / UNIT) % UNIT);
        check("cmp_hour", hour_o, m_rem / (UNIT * UNIT));
        check("cmp_busy", busy_o, (m_st == M_RUN) ? 1 : 0);
        check("cmp_done", done_o, m_done ? 1 : 0);
    end

    task automatic load_time(input int h, input int m, input int s);
        hour_i = 4'(h);
        min_i  = 3'(m);
        sec_i  = 3'(s);
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_i = 1'b0; start_i = 1'b0; pause_i = 1'b0;
        sec_i = 3'd0; min_i = 3'd0; hour_i = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_sec",  sec_o,  0);
        check("reset_min",  min_o,  0);
        check("reset_hour", hour_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        rst = 1'b0;

        // Basic countdown from 0:0:2
        load_time(0, 0, 2);
        start_pulse();
        check("basic_busy_e0", busy_o, 1);
        repeat (9) @(negedge clk);
        check("basic_sec_e9", sec_o, 2);
        @(negedge clk);
        check("basic_sec_e10", sec_o, 1);
        repeat (10) @(negedge clk);
        check("basic_done_e20", done_o, 1);
`ifdef AUTO_RELOAD_EN
        check("basic_reload_sec_e20", sec_o, 2);
        check("basic_busy_e20", busy_o, 1);
`else
        check("basic_sec_e20", sec_o, 0);
        check("basic_busy_e20", busy_o, 0);
        @(negedge clk);
        check("basic_done_e21", done_o, 0);
        start_pulse();
        check("done_start_busy", busy_o, 0);
        check("done_start_done", done_o, 0);
`endif
        do_reset();

        // Borrow across minutes and hours from 1:0:0
        load_time(1, 0, 0);
        start_pulse();
        repeat (10) @(negedge clk);
        check("borrow_hour", hour_o, 0);
        check("borrow_min",  min_o,  5);
        check("borrow_sec",  sec_o,  5);
        repeat (60) @(negedge clk);
        check("borrow_min_e70", min_o, 4);
        check("borrow_sec_e70", sec_o, 5);
        load_time(3, 3, 3);
        check("run_load_ignored_min", min_o, 4);
        check("run_load_ignored_sec", sec_o, 5);
        check("run_load_busy", busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_sec",  sec_o,  0);
        check("rst_run_min",  min_o,  0);
        check("rst_run_busy", busy_o, 0);

        // Pause and resume from 0:0:3
        load_time(0, 0, 3);
        start_pulse();
        repeat (14) @(negedge clk);
        pause_i = 1'b1;
        @(negedge clk);
        pause_i = 1'b0;
        check("pause_sec",  sec_o,  2);
        check("pause_busy", busy_o, 0);
        repeat (40) @(negedge clk);
        check("pause_hold_sec", sec_o, 2);
        start_pulse();
        check("resume_busy", busy_o, 1);
        repeat (4) @(negedge clk);
        check("resume_sec_r4", sec_o, 2);
        @(negedge clk);
        check("resume_sec_r5", sec_o, 1);
        do_reset();

        // Clamp of out-of-range preset
        load_time(13, 6, 7);
        check("clamp_sec",  sec_o,  5);
        check("clamp_min",  min_o,  5);
        check("clamp_hour", hour_o, 11);

        // Zero preset goes straight to DONE
        load_time(0, 0, 0);
        start_pulse();
        check("zero_done", done_o, 1);
        check("zero_busy", busy_o, 0);
        @(negedge clk);
        check("zero_done_next", done_o, 0);

        // load_i and start_i together: load wins, stays IDLE
        sec_i = 3'd0; min_i = 3'd1; hour_i = 4'd0;
        load_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0; start_i = 1'b0;
        check("prio_min",  min_o,  1);
        check("prio_busy", busy_o, 0);
        repeat (12) @(negedge clk);
        check("prio_hold_min", min_o, 1);
        check("prio_hold_sec", sec_o, 0);

`ifdef AUTO_RELOAD_EN
        do_reset();
        load_time(0, 0, 1);
        start_pulse();
        repeat (9) @(negedge clk);
        check("auto_done_e9", done_o, 0);
        @(negedge clk);
        check("auto_done_e10", done_o, 1);
        check("auto_sec_e10", sec_o, 1);
        repeat (10) @(negedge clk);
        check("auto_done_e20", done_o, 1);
        repeat (10) @(negedge clk);
        check("auto_done_e30", done_o, 1);
        check("auto_busy_e30", busy_o, 1);
        check("auto_sec_e30", sec_o, 1);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
